// File: rtl/conv33_window_gen.sv
// Raster-stream to 3x3 sliding-window generator (stride 1, unpadded) with two line buffers.
// Optional CONV33_WIN_CNT_EN adds a saturating per-frame window handshake counter (win_cnt).
module conv33_window_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  done,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic [DATA_WIDTH-1:0] pix_data,
  output logic                  valid_out,
  input  logic                  ready_in,
`ifdef CONV33_WIN_CNT_EN
  output logic [15:0]           win_cnt,
`endif
  output logic [DATA_WIDTH-1:0] out_0_0,
  output logic [DATA_WIDTH-1:0] out_0_1,
  output logic [DATA_WIDTH-1:0] out_0_2,
  output logic [DATA_WIDTH-1:0] out_1_0,
  output logic [DATA_WIDTH-1:0] out_1_1,
  output logic [DATA_WIDTH-1:0] out_1_2,
  output logic [DATA_WIDTH-1:0] out_2_0,
  output logic [DATA_WIDTH-1:0] out_2_1,
  output logic [DATA_WIDTH-1:0] out_2_2
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t                state, state_nxt;
  logic [RW-1:0]         row;
  logic [CW-1:0]         col;
  logic [DATA_WIDTH-1:0] lb0 [IMG_W];
  logic [DATA_WIDTH-1:0] lb1 [IMG_W];
  logic [DATA_WIDTH-1:0] w   [3][3];
  logic                  accept, hs, last_px, win_pos;

  assign accept  = pix_valid && pix_ready;
  assign hs      = valid_out && ready_in;
  assign last_px = (row == ROW_LAST) && (col == COL_LAST);
  assign win_pos = (row >= RW'(2)) && (col >= CW'(2));

  always_comb begin
    state_nxt = state;
    pix_ready = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN: begin
        pix_ready = !valid_out || ready_in;
        if (accept && last_px) state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if (hs) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      row       <= '0;
      col       <= '0;
      valid_out <= 1'b0;
      for (int unsigned r = 0; r < 3; r++)
        for (int unsigned c = 0; c < 3; c++)
          w[r][c] <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && start) begin
        row <= '0;
        col <= '0;
      end else if (accept) begin
        if (col == COL_LAST) begin
          col <= '0;
          if (row != ROW_LAST) row <= row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      // A window completed by this accept replaces any window handshaking now.
      if (accept && win_pos) valid_out <= 1'b1;
      else if (hs)           valid_out <= 1'b0;
      if (accept) begin
        for (int unsigned r = 0; r < 3; r++) begin
          w[r][0] <= w[r][1];
          w[r][1] <= w[r][2];
        end
        w[0][2] <= lb1[col];
        w[1][2] <= lb0[col];
        w[2][2] <= pix_data;
      end
    end
  end

  // Line buffers are plain RAM: no reset, read-before-write at the same column.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col] <= lb0[col];
      lb0[col] <= pix_data;
    end
  end

`ifdef CONV33_WIN_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                         win_cnt <= '0;
    else if (state == S_IDLE && start) win_cnt <= '0;
    else if (hs && win_cnt != 16'hFFFF) win_cnt <= win_cnt + 16'd1;
  end
`endif

  assign out_0_0 = w[0][0];
  assign out_0_1 = w[0][1];
  assign out_0_2 = w[0][2];
  assign out_1_0 = w[1][0];
  assign out_1_1 = w[1][1];
  assign out_1_2 = w[1][2];
  assign out_2_0 = w[2][0];
  assign out_2_1 = w[2][1];
  assign out_2_2 = w[2][2];

endmodule
